// File: rtl/buzzer_arbiter.sv
// rtl/buzzer_arbiter.sv - fixed-priority, preemptive four-source buzzer arbiter with tone and gap timing
module buzzer_arbiter #(
    parameter logic [15:0] HALF_0    = 16'd24000,
    parameter logic [15:0] HALF_1    = 16'd12000,
    parameter logic [15:0] HALF_2    = 16'd6000,
    parameter logic [15:0] HALF_3    = 16'd3000,
    parameter logic [7:0]  DUR_0     = 8'd40,
    parameter logic [7:0]  DUR_1     = 8'd40,
    parameter logic [7:0]  DUR_2     = 8'd150,
    parameter logic [7:0]  DUR_3     = 8'd20,
    parameter logic [7:0]  GAP_TICKS = 8'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_en,
    input  logic [3:0] req,
    input  logic       mute,
    output logic       buzzer,
    output logic       busy,
    output logic [1:0] active_src,
    output logic [3:0] ack
);

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    state_t      state, state_nx;
    logic [3:0]  pending, eff, grant_oh;
    logic        grant;
    logic [1:0]  top, src_nx;
    logic [15:0] tone_cnt, tone_nx;
    logic        phase, phase_nx;
    logic [7:0]  dur_cnt, dur_nx, gap_cnt, gap_nx;

    function automatic logic [15:0] half_of(input logic [1:0] s);
        case (s)
            2'd0:    half_of = HALF_0;
            2'd1:    half_of = HALF_1;
            2'd2:    half_of = HALF_2;
            default: half_of = HALF_3;
        endcase
    endfunction

    function automatic logic [7:0] dur_of(input logic [1:0] s);
        logic [7:0] d;
        case (s)
            2'd0:    d = DUR_0;
            2'd1:    d = DUR_1;
            2'd2:    d = DUR_2;
            default: d = DUR_3;
        endcase
        dur_of = (d == 8'd0) ? 8'd1 : d;
    endfunction

    assign eff = pending | req;

    always_comb begin
        top = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (eff[i]) top = i[1:0];
        end
    end

    always_comb begin
        state_nx = state;
        tone_nx  = tone_cnt;
        phase_nx = phase;
        dur_nx   = dur_cnt;
        gap_nx   = gap_cnt;
        src_nx   = active_src;
        grant    = 1'b0;
        case (state)
            IDLE: begin
                if (eff != 4'd0) grant = 1'b1;
            end
            PLAY: begin
                // Preemption wins over any tone/duration bookkeeping this cycle
                if (eff != 4'd0 && top > active_src) begin
                    grant = 1'b1;
                end else begin
                    if (tone_cnt == 16'd0) begin
                        tone_nx  = half_of(active_src) - 16'd1;
                        phase_nx = ~phase;
                    end else begin
                        tone_nx = tone_cnt - 16'd1;
                    end
                    if (tick_en) begin
                        if (dur_cnt <= 8'd1) begin
                            if (GAP_TICKS != 8'd0) begin
                                state_nx = GAP;
                                gap_nx   = GAP_TICKS;
                            end else begin
                                state_nx = IDLE;
                            end
                        end else begin
                            dur_nx = dur_cnt - 8'd1;
                        end
                    end
                end
            end
            GAP: begin
                if (tick_en) begin
                    if (gap_cnt <= 8'd1) state_nx = IDLE;
                    else gap_nx = gap_cnt - 8'd1;
                end
            end
            default: state_nx = IDLE;
        endcase
        if (grant) begin
            state_nx = PLAY;
            src_nx   = top;
            tone_nx  = half_of(top) - 16'd1;
            phase_nx = 1'b1;
            dur_nx   = dur_of(top);
        end
        grant_oh = grant ? (4'b0001 << top) : 4'b0000;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            pending    <= 4'd0;
            buzzer     <= 1'b0;
            busy       <= 1'b0;
            active_src <= 2'd0;
            ack        <= 4'd0;
            tone_cnt   <= 16'd0;
            phase      <= 1'b0;
            dur_cnt    <= 8'd0;
            gap_cnt    <= 8'd0;
        end else begin
            state      <= state_nx;
            pending    <= eff & ~grant_oh;
            ack        <= grant_oh;
            active_src <= src_nx;
            busy       <= (state_nx != IDLE);
            buzzer     <= (state_nx == PLAY) & phase_nx & ~mute;
            tone_cnt   <= tone_nx;
            phase      <= phase_nx;
            dur_cnt    <= dur_nx;
            gap_cnt    <= gap_nx;
        end
    end

endmodule

// File: tb/tb_buzzer_arbiter.sv
// tb/tb_buzzer_arbiter.sv - directed and randomized checks of buzzer_arbiter against an elapsed-time model
module tb_buzzer_arbiter;

    localparam int HALF_T[4] = '{4, 6, 3, 5};
    localparam int DUR_T[4]  = '{3, 2, 4, 0};
    localparam int GAP       = 2;

    logic       clk = 1'b0;
    logic       reset, tick_en, mute;
    logic [3:0] req;
    logic       buzzer, busy;
    logic [1:0] active_src;
    logic [3:0] ack;

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model: mode 0 silent/idle, 1 sounding, 2 gap; timing kept as elapsed counts since grant
    int         m_mode, m_src, m_age, m_ticks, m_gticks;
    logic [3:0] m_pend, m_ack;

    buzzer_arbiter #(
        .HALF_0(16'd4), .HALF_1(16'd6), .HALF_2(16'd3), .HALF_3(16'd5),
        .DUR_0(8'd3), .DUR_1(8'd2), .DUR_2(8'd4), .DUR_3(8'd0),
        .GAP_TICKS(8'd2)
    ) dut (
        .clk(clk), .reset(reset), .tick_en(tick_en), .req(req), .mute(mute),
        .buzzer(buzzer), .busy(busy), .active_src(active_src), .ack(ack)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int dur_len(input int s);
        return (DUR_T[s] == 0) ? 1 : DUR_T[s];
    endfunction

    task automatic model_reset();
        m_mode = 0; m_src = 0; m_age = 0; m_ticks = 0; m_gticks = 0;
        m_pend = 4'd0; m_ack = 4'd0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic t);
        logic [3:0] e;
        int         hi;
        bit         g;
        e  = m_pend | r;
        hi = -1;
        for (int i = 0; i < 4; i++) if (e[i]) hi = i;
        g = (m_mode == 0 && hi >= 0) || (m_mode == 1 && hi > m_src);
        if (g) begin
            m_src   = hi;
            m_mode  = 1;
            m_age   = 0;
            m_ticks = 0;
            m_ack   = 4'(1 << hi);
            m_pend  = e & ~m_ack;
        end else begin
            m_ack  = 4'd0;
            m_pend = e;
            if (m_mode == 1) begin
                m_age++;
                if (t) begin
                    m_ticks++;
                    if (m_ticks == dur_len(m_src)) begin
                        m_mode   = (GAP > 0) ? 2 : 0;
                        m_gticks = 0;
                    end
                end
            end else if (m_mode == 2 && t) begin
                m_gticks++;
                if (m_gticks == GAP) m_mode = 0;
            end
        end
    endtask

    task automatic compare_all(input logic m);
        logic exp_buz;
        exp_buz = (m_mode == 1) && (((m_age / HALF_T[m_src]) % 2) == 0) && !m;
        check("buzzer", 32'(buzzer), 32'(exp_buz));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("ack", 32'(ack), 32'(m_ack));
        check("active_src", 32'(active_src), 32'(m_src));
    endtask

    task automatic step(input logic [3:0] r, input logic t, input logic m);
        req = r; tick_en = t; mute = m;
        @(posedge clk);
        model_edge(r, t);
        #1;
        compare_all(m);
        @(negedge clk);
        req = 4'd0; tick_en = 1'b0;
        cyc++;
    endtask

    function automatic logic sched_tick();
        return (cyc % 20) == 19;
    endfunction

    task automatic run(input int n, input logic m);
        for (int i = 0; i < n; i++) step(4'd0, sched_tick(), m);
    endtask

    initial begin
        reset = 1'b1; req = 4'd0; tick_en = 1'b0; mute = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_buzzer", 32'(buzzer), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ack", 32'(ack), 32'd0);
        check("reset_src", 32'(active_src), 32'd0);
        reset = 1'b0;

        // single source 0 tone, duration then gap then idle
        run(5, 1'b0);
        step(4'b0001, sched_tick(), 1'b0);
        run(120, 1'b0);

        // simultaneous 2 and 0: priority order, each with its own gap
        step(4'b0101, sched_tick(), 1'b0);
        run(300, 1'b0);

        // source 3 preempts source 0 mid-tone
        step(4'b0001, sched_tick(), 1'b0);
        run(10, 1'b0);
        step(4'b1000, sched_tick(), 1'b0);
        run(120, 1'b0);

        // lower-priority request waits for source 2 plus its gap
        step(4'b0100, sched_tick(), 1'b0);
        run(10, 1'b0);
        step(4'b0010, sched_tick(), 1'b0);
        run(260, 1'b0);

        // muted tone: identical sequencing, silent pin
        step(4'b0010, sched_tick(), 1'b1);
        run(120, 1'b1);

        // reset mid-tone with a pending replay
        step(4'b0001, sched_tick(), 1'b0);
        run(10, 1'b0);
        step(4'b0001, sched_tick(), 1'b0);
        run(3, 1'b0);
        check("pre_reset_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        model_reset();
        check("async_buzzer", 32'(buzzer), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        check("held_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(150, 1'b0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(1, 15)) : 4'd0;
            step(r, ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0));
        end
        run(400, 1'b0);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
